// File: rtl/cnn_stream_pkg.sv
// Shared definitions for the CNN pixel-stream blocks.
// Contents:
//   collect_state_t - collector FSM states (COLLECT, HOLD)
//   pixel_count()   - pixels in a square map of the given edge length
//   count_w()       - width of a counter that must reach pixel_count() itself
package cnn_stream_pkg;

  typedef enum logic {COLLECT, HOLD} collect_state_t;

  function automatic int pixel_count(input int width);
    return width * width;
  endfunction

  function automatic int count_w(input int width);
    return $clog2(width * width + 1);
  endfunction

endpackage

// File: rtl/feature_map_collector_pos_counter.sv
// pixel_pos_counter: raster position counter for a map of Pixels pixels.
// Ports:
//   clk, res_n    clock, async active-low reset
//   advance       one pixel accepted this cycle
//   clear         map handed off; restart at position 0 (wins over advance)
//   count         pixels accepted so far in the current map
//   at_last_slot  next accepted pixel fills the final raster slot
module pixel_pos_counter #(
  parameter int Pixels = 16,
  parameter int CountW = 5
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              advance,
  input  logic              clear,
  output logic [CountW-1:0] count,
  output logic              at_last_slot
);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)       count <= '0;
    else if (clear)   count <= '0;
    else if (advance) count <= count + CountW'(1);
  end

  assign at_last_slot = (count == CountW'(Pixels - 1));

endmodule

// File: rtl/feature_map_collector.sv
// feature_map_collector: reassembles a raster pixel stream into one
// ImageWidth x ImageWidth feature map and presents it as a parallel word.
// Ports:
//   clk, res_n                      clock, async active-low reset
//   in_valid/in_ready/in_data       upstream pixel handshake
//   in_last                         pixel ends the map (only on accept)
//   frame_valid/frame_ready         downstream map handshake
//   frame_data                      pixel k at [k*BitSize +: BitSize]
//   frame_count                     real pixels in the presented map
//   short_err                       presented map was cut short by in_last
module feature_map_collector
  import cnn_stream_pkg::*;
#(
  parameter int BitSize    = 32,
  parameter int ImageWidth = 4
) (
  input  logic                                       clk,
  input  logic                                       res_n,
  input  logic                                       in_valid,
  input  logic [BitSize-1:0]                         in_data,
  input  logic                                       in_last,
  output logic                                       in_ready,
  output logic                                       frame_valid,
  input  logic                                       frame_ready,
  output logic [pixel_count(ImageWidth)*BitSize-1:0] frame_data,
  output logic [count_w(ImageWidth)-1:0]             frame_count,
  output logic                                       short_err
);

  localparam int PixelCount = pixel_count(ImageWidth);
  localparam int CountW     = count_w(ImageWidth);

  collect_state_t    state, state_nxt;
  logic [CountW-1:0] count;
  logic              at_last_slot;
  logic              accept, map_done, handoff;

  assign accept   = in_valid && in_ready;
  assign map_done = accept && (at_last_slot || in_last);
  assign handoff  = frame_valid && frame_ready;

  pixel_pos_counter #(
    .Pixels (PixelCount),
    .CountW (CountW)
  ) u_pos (
    .clk          (clk),
    .res_n        (res_n),
    .advance      (accept),
    .clear        (handoff),
    .count        (count),
    .at_last_slot (at_last_slot)
  );

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    frame_valid = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (map_done) state_nxt = HOLD;
      end
      HOLD: begin
        frame_valid = 1'b1;
        if (frame_ready) state_nxt = COLLECT;
      end
    endcase
  end

  // map_done implies in_last or a full map, so "short" is simply "not full".
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)        short_err <= 1'b0;
    else if (map_done) short_err <= !at_last_slot;
    else if (handoff)  short_err <= 1'b0;
  end

  // One storage slot per raster position. Slots at or beyond count are
  // masked to zero on output, so leftovers from an earlier, longer map
  // never show up and no clearing pass is required.
  for (genvar k = 0; k < PixelCount; k++) begin : g_px
    logic [BitSize-1:0] px;

    always_ff @(posedge clk or negedge res_n) begin
      if (!res_n)                                   px <= '0;
      else if (accept && (count == CountW'(k)))     px <= in_data;
    end

    assign frame_data[k*BitSize +: BitSize] = (count > CountW'(k)) ? px : '0;
  end

  assign frame_count = frame_valid ? count : '0;

endmodule
